// File: rtl/b2d_pkg.sv
// Shared constants and types for the 32-bit binary to ten-digit BCD converter.
package b2d_pkg;
  localparam int NUM_DIGITS    = 10;
  localparam int IN_WIDTH      = 32;
  localparam int BITS_PER_STEP = 4;
  localparam int NUM_STEPS     = 8;
  localparam int BCD_WIDTH     = NUM_DIGITS * 4;
  localparam int STEP_WIDTH    = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/binary_to_decimal32_if.sv
// Operand and BCD digit bundle between the converter and its user.
// Optional `valid` flag is present when B2D_VALID_OUT_EN is defined.
interface binary_to_decimal32_if;
  import b2d_pkg::*;

  logic [IN_WIDTH-1:0] binaryInput;
  bcd_digit_t          billions;
  bcd_digit_t          hundred_millions;
  bcd_digit_t          ten_millions;
  bcd_digit_t          millions;
  bcd_digit_t          hundred_thousands;
  bcd_digit_t          ten_thousands;
  bcd_digit_t          thousands;
  bcd_digit_t          hundreds;
  bcd_digit_t          tens;
  bcd_digit_t          units;
`ifdef B2D_VALID_OUT_EN
  logic                valid;
`endif

  modport master (
    output binaryInput,
    input  billions, hundred_millions, ten_millions, millions,
           hundred_thousands, ten_thousands, thousands, hundreds, tens, units
`ifdef B2D_VALID_OUT_EN
    , input valid
`endif
  );

  modport slave (
    input  binaryInput,
    output billions, hundred_millions, ten_millions, millions,
           hundred_thousands, ten_thousands, thousands, hundreds, tens, units
`ifdef B2D_VALID_OUT_EN
    , output valid
`endif
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Single BCD digit correction cell: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import b2d_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  // Add-3 correction applied ahead of the shift
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/binary_to_decimal32.sv
// Sequential double-dabble converter, 4 operand bits per clock, 8 steps.
// Build option B2D_VALID_OUT_EN adds a registered `valid` output.
module binary_to_decimal32
  import b2d_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  binary_to_decimal32_if.slave   bus
);

  state_t                 state_q;
  state_t                 state_next;
  logic [IN_WIDTH-1:0]    src_q;
  logic [IN_WIDTH-1:0]    shift_q;
  logic [BCD_WIDTH-1:0]   bcd_q;
  logic [STEP_WIDTH-1:0]  step_q;
  logic                   busy_q;
  logic                   load_pending_q;
  logic [BCD_WIDTH-1:0]   digits_q;
  logic                   load;
  logic                   done;
  logic [BCD_WIDTH-1:0]   step_bcd;
  logic [IN_WIDTH-1:0]    step_shift;
`ifdef B2D_VALID_OUT_EN
  logic                   valid_q;
`endif

  // Four chained add-3/shift stages form one clock's worth of work
  for (genvar s = 0; s < BITS_PER_STEP; s++) begin : g_stage
    logic [BCD_WIDTH-1:0] bcd_in;
    logic [BCD_WIDTH-1:0] bcd_adj;
    logic [BCD_WIDTH-1:0] bcd_out;
    logic [IN_WIDTH-1:0]  shift_in;
    logic [IN_WIDTH-1:0]  shift_out;

    if (s == 0) begin : g_head
      assign bcd_in   = bcd_q;
      assign shift_in = shift_q;
    end else begin : g_tail
      assign bcd_in   = g_stage[s-1].bcd_out;
      assign shift_in = g_stage[s-1].shift_out;
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
      bcd_digit_adj u_adj (
        .din  (bcd_in[4*d +: 4]),
        .dout (bcd_adj[4*d +: 4])
      );
    end

    assign bcd_out   = {bcd_adj[BCD_WIDTH-2:0], shift_in[IN_WIDTH-1]};
    assign shift_out = {shift_in[IN_WIDTH-2:0], 1'b0};
  end

  assign step_bcd   = g_stage[BITS_PER_STEP-1].bcd_out;
  assign step_shift = g_stage[BITS_PER_STEP-1].shift_out;

  // Next-state logic: a changed operand (or post-reset load) always restarts
  always_comb begin
    state_next = state_q;
    load       = (bus.binaryInput != src_q) || load_pending_q;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (load) begin
          state_next = RUN;
        end else if (step_q == 4'(NUM_STEPS - 1)) begin
          state_next = IDLE;
          done       = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Operand latch, working registers and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q          <= 32'd0;
      shift_q        <= 32'd0;
      bcd_q          <= 40'd0;
      step_q         <= 4'd0;
      busy_q         <= 1'b0;
      load_pending_q <= 1'b1;
      digits_q       <= 40'd0;
`ifdef B2D_VALID_OUT_EN
      valid_q        <= 1'b0;
`endif
    end else begin
      load_pending_q <= 1'b0;
      busy_q         <= (state_next == RUN);
      if (load) begin
        src_q   <= bus.binaryInput;
        shift_q <= bus.binaryInput;
        bcd_q   <= 40'd0;
        step_q  <= 4'd0;
`ifdef B2D_VALID_OUT_EN
        valid_q <= 1'b0;
`endif
      end else if (state_q == RUN) begin
        shift_q <= step_shift;
        bcd_q   <= step_bcd;
        step_q  <= step_q + 4'd1;
        if (done) begin
          digits_q <= step_bcd;
`ifdef B2D_VALID_OUT_EN
          valid_q  <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.billions          = digits_q[39:36];
  assign bus.hundred_millions  = digits_q[35:32];
  assign bus.ten_millions      = digits_q[31:28];
  assign bus.millions          = digits_q[27:24];
  assign bus.hundred_thousands = digits_q[23:20];
  assign bus.ten_thousands     = digits_q[19:16];
  assign bus.thousands         = digits_q[15:12];
  assign bus.hundreds          = digits_q[11:8];
  assign bus.tens              = digits_q[7:4];
  assign bus.units             = digits_q[3:0];
`ifdef B2D_VALID_OUT_EN
  assign bus.valid             = valid_q;
`endif

endmodule

// File: tb/tb_binary_to_decimal32.sv
// Bench for binary_to_decimal32: decimal reference model via division,
// exact 9-edge latency, hold-during-run, abort and mid-conversion reset.
module tb_binary_to_decimal32;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [31:0] cur_in;
  logic [39:0] exp_out;

  binary_to_decimal32_if bif();

  binary_to_decimal32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got tests=%0d required completion", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] ref_bcd(input logic [31:0] v);
    logic [39:0]     r;
    longint unsigned x;
    r = 40'd0;
    x = longint'(v);
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    return r;
  endfunction

  function automatic logic [39:0] dut_out();
    return {bif.billions, bif.hundred_millions, bif.ten_millions, bif.millions,
            bif.hundred_thousands, bif.ten_thousands, bif.thousands,
            bif.hundreds, bif.tens, bif.units};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bif.binaryInput = 32'd0;
    cur_in = 32'd0;
    exp_out = 40'd0;
    #50;
    tests++;
    if (dut_out() !== 40'd0) begin
      fails++;
      $display("FAIL reset_during: got %h required %h", dut_out(), 40'd0);
    end
`ifdef B2D_VALID_OUT_EN
    tests++;
    if (bif.valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b required 0", bif.valid);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (dut_out() !== 40'd0) begin
      fails++;
      $display("FAIL reset_hold: got %h required %h", dut_out(), 40'd0);
    end
    @(posedge clk);
    #1;
    tests++;
    if (dut_out() !== 40'd0) begin
      fails++;
      $display("FAIL reset_first_load: got %h required %h", dut_out(), 40'd0);
    end
`ifdef B2D_VALID_OUT_EN
    tests++;
    if (bif.valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_valid_rise: got %b required 1", bif.valid);
    end
`endif
  endtask

  task automatic test_known();
    logic [31:0] vals [4];
    vals[0] = 32'd123456789;
    vals[1] = 32'd4294967295;
    vals[2] = 32'd20220421;
    vals[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bif.binaryInput = vals[i];
      cur_in = vals[i];
      for (int e = 1; e <= 8; e++) begin
        @(posedge clk);
        #1;
        tests++;
        if (dut_out() !== exp_out) begin
          fails++;
          $display("FAIL known_hold[%0d] edge %0d: got %h required %h", i, e, dut_out(), exp_out);
        end
      end
      @(posedge clk);
      #1;
      exp_out = ref_bcd(vals[i]);
      tests++;
      if (dut_out() !== exp_out) begin
        fails++;
        $display("FAIL known_result[%0d]: got %h required %h", i, dut_out(), exp_out);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = (i % 2 == 0) ? $urandom : $urandom_range(0, 99999);
      if (v == cur_in) v = v ^ 32'd1;
      @(negedge clk);
      bif.binaryInput = v;
      cur_in = v;
      repeat (8) @(posedge clk);
      #1;
      tests++;
      if (dut_out() !== exp_out) begin
        fails++;
        $display("FAIL random_hold[%0d] in=%0d: got %h required %h", i, v, dut_out(), exp_out);
      end
      @(posedge clk);
      #1;
      exp_out = ref_bcd(v);
      tests++;
      if (dut_out() !== exp_out) begin
        fails++;
        $display("FAIL random_result[%0d] in=%0d: got %h required %h", i, v, dut_out(), exp_out);
      end
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    bif.binaryInput = 32'd999;
    cur_in = 32'd999;
    repeat (9) @(posedge clk);
    #1;
    exp_out = ref_bcd(32'd999);
    tests++;
    if (dut_out() !== exp_out) begin
      fails++;
      $display("FAIL abort_setup_999: got %h required %h", dut_out(), exp_out);
    end
    @(negedge clk);
    bif.binaryInput = 32'd123;
    cur_in = 32'd123;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bif.binaryInput = 32'd1000;
    cur_in = 32'd1000;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      tests++;
      if (dut_out() !== exp_out) begin
        fails++;
        $display("FAIL abort_hold edge %0d: got %h required %h", e, dut_out(), exp_out);
      end
    end
    @(posedge clk);
    #1;
    exp_out = ref_bcd(32'd1000);
    tests++;
    if (dut_out() !== exp_out) begin
      fails++;
      $display("FAIL abort_result: got %h required %h", dut_out(), exp_out);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bif.binaryInput = 32'd123456789;
    cur_in = 32'd123456789;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_out = 40'd0;
    tests++;
    if (dut_out() !== 40'd0) begin
      fails++;
      $display("FAIL reset_mid_clear: got %h required %h", dut_out(), 40'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      tests++;
      if (dut_out() !== 40'd0) begin
        fails++;
        $display("FAIL reset_mid_hold edge %0d: got %h required %h", e, dut_out(), 40'd0);
      end
`ifdef B2D_VALID_OUT_EN
      tests++;
      if (bif.valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_valid edge %0d: got %b required 0", e, bif.valid);
      end
`endif
    end
    @(posedge clk);
    #1;
    exp_out = ref_bcd(32'd123456789);
    tests++;
    if (dut_out() !== exp_out) begin
      fails++;
      $display("FAIL reset_mid_result: got %h required %h", dut_out(), exp_out);
    end
`ifdef B2D_VALID_OUT_EN
    tests++;
    if (bif.valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_valid_rise: got %b required 1", bif.valid);
    end
`endif
  endtask

  task automatic test_stable();
    for (int e = 0; e < 20; e++) begin
      @(posedge clk);
      #1;
      tests++;
      if (dut_out() !== exp_out) begin
        fails++;
        $display("FAIL stable edge %0d: got %h required %h", e, dut_out(), exp_out);
      end
`ifdef B2D_VALID_OUT_EN
      tests++;
      if (bif.valid !== 1'b1) begin
        fails++;
        $display("FAIL stable_valid edge %0d: got %b required 1", e, bif.valid);
      end
`endif
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_known();
    test_random();
    test_abort();
    test_reset_mid();
    test_stable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
